// File: rtl/jtag_tap_ctrl.sv
// -----------------------------------------------------------------------------
// jtag_tap_ctrl
// IEEE 1149.1-style TAP controller for the s9234 boundary-scan (BSR) and
// internal scan (ISR) chains. Decodes TMS into the 16-state TAP FSM, holds a
// 3-bit instruction register, steers capture/shift/update strobes to the
// selected chain, drives bs_en and muxes TDO.
//
// Ports:
//   CK          in   TCK; all state updates on the rising edge
//   reset       in   synchronous active-high, forces Test-Logic-Reset
//   TMS         in   test mode select
//   TDI         in   serial data in (IR / bypass internally)
//   TDO_BSR     in   serial out of the BSR chain
//   TDO_ISR     in   serial out of the ISR chain
//   TDO         out  serial data out (0 outside Shift-DR / Shift-IR)
//   TDO_EN      out  high in Shift-DR or Shift-IR
//   clockdr     out  BSR capture/shift enable
//   shiftdr     out  BSR shift select
//   updatedr    out  BSR update strobe
//   clockdr_is  out  ISR capture/shift enable
//   shiftdr_is  out  ISR shift select
//   updatedr_is out  ISR update strobe
//   bs_en       out  boundary test mode enable (EXTEST or INTSCAN active)
//   tap_state   out  current FSM state encoding
//   ir_q        out  active instruction
// -----------------------------------------------------------------------------
module jtag_tap_ctrl #(
  parameter int             IR_W      = 3,
  parameter logic [IR_W-1:0] I_EXTEST  = 3'b000,
  parameter logic [IR_W-1:0] I_SAMPLE  = 3'b001,
  parameter logic [IR_W-1:0] I_INTSCAN = 3'b010,
  parameter logic [IR_W-1:0] I_BYPASS  = 3'b111
) (
  input  logic            CK,
  input  logic            reset,
  input  logic            TMS,
  input  logic            TDI,
  input  logic            TDO_BSR,
  input  logic            TDO_ISR,
  output logic            TDO,
  output logic            TDO_EN,
  output logic            clockdr,
  output logic            shiftdr,
  output logic            updatedr,
  output logic            clockdr_is,
  output logic            shiftdr_is,
  output logic            updatedr_is,
  output logic            bs_en,
  output logic [3:0]      tap_state,
  output logic [IR_W-1:0] ir_q
);

  typedef enum logic [3:0] {
    S_TLR   = 4'hF, S_RTI   = 4'hC,
    S_SELDR = 4'h7, S_CAPDR = 4'h6, S_SHDR  = 4'h2, S_EX1DR = 4'h1,
    S_PSDR  = 4'h3, S_EX2DR = 4'h0, S_UPDDR = 4'h5,
    S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR  = 4'hA, S_EX1IR = 4'h9,
    S_PSIR  = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD
  } tap_state_e;

  tap_state_e      r_state;
  tap_state_e      w_next;
  logic [IR_W-1:0] r_ir_sr;
  logic [IR_W-1:0] r_ir_q;
  logic            r_byp;
  logic            w_sel_bs;
  logic            w_sel_is;
  logic            w_tdo;

  // TAP state register
  always_ff @(posedge CK) begin
    if (reset) begin
      r_state <= S_TLR;
    end else begin
      r_state <= w_next;
    end
  end

  // TAP next-state decode from TMS
  always_comb begin
    w_next = S_TLR;
    case (r_state)
      S_TLR:   w_next = TMS ? S_TLR   : S_RTI;
      S_RTI:   w_next = TMS ? S_SELDR : S_RTI;
      S_SELDR: w_next = TMS ? S_SELIR : S_CAPDR;
      S_CAPDR: w_next = TMS ? S_EX1DR : S_SHDR;
      S_SHDR:  w_next = TMS ? S_EX1DR : S_SHDR;
      S_EX1DR: w_next = TMS ? S_UPDDR : S_PSDR;
      S_PSDR:  w_next = TMS ? S_EX2DR : S_PSDR;
      S_EX2DR: w_next = TMS ? S_UPDDR : S_SHDR;
      S_UPDDR: w_next = TMS ? S_SELDR : S_RTI;
      S_SELIR: w_next = TMS ? S_TLR   : S_CAPIR;
      S_CAPIR: w_next = TMS ? S_EX1IR : S_SHIR;
      S_SHIR:  w_next = TMS ? S_EX1IR : S_SHIR;
      S_EX1IR: w_next = TMS ? S_UPDIR : S_PSIR;
      S_PSIR:  w_next = TMS ? S_EX2IR : S_PSIR;
      S_EX2IR: w_next = TMS ? S_UPDIR : S_SHIR;
      S_UPDIR: w_next = TMS ? S_SELDR : S_RTI;
      default: w_next = S_TLR;
    endcase
  end

  // Instruction shift register and active instruction.
  // ir_q is forced to BYPASS on the edge entering TLR as well as every edge
  // spent in TLR, so the instruction already reads BYPASS in the first TLR
  // cycle even when the path there crossed Update-IR.
  always_ff @(posedge CK) begin
    if (reset) begin
      r_ir_sr <= '0;
      r_ir_q  <= I_BYPASS;
    end else begin
      case (r_state)
        S_CAPIR: r_ir_sr <= IR_W'(2'b01);
        S_SHIR:  r_ir_sr <= {TDI, r_ir_sr[IR_W-1:1]};
        default: r_ir_sr <= r_ir_sr;
      endcase
      if ((r_state == S_TLR) || (w_next == S_TLR)) begin
        r_ir_q <= I_BYPASS;
      end else if (r_state == S_UPDIR) begin
        r_ir_q <= r_ir_sr;
      end else begin
        r_ir_q <= r_ir_q;
      end
    end
  end

  // One-bit bypass register
  always_ff @(posedge CK) begin
    if (reset) begin
      r_byp <= 1'b0;
    end else begin
      case (r_state)
        S_CAPDR: r_byp <= 1'b0;
        S_SHDR:  r_byp <= TDI;
        default: r_byp <= r_byp;
      endcase
    end
  end

  // Chain selection; every undefined code falls through to bypass
  assign w_sel_bs = (r_ir_q == I_EXTEST) || (r_ir_q == I_SAMPLE);
  assign w_sel_is = (r_ir_q == I_INTSCAN);

  // TDO source select
  always_comb begin
    w_tdo = 1'b0;
    case (r_state)
      S_SHIR: w_tdo = r_ir_sr[0];
      S_SHDR: begin
        if (w_sel_bs) begin
          w_tdo = TDO_BSR;
        end else if (w_sel_is) begin
          w_tdo = TDO_ISR;
        end else begin
          w_tdo = r_byp;
        end
      end
      default: w_tdo = 1'b0;
    endcase
  end

  // Strobes decode only from registered state, so they move just after CK rises
  assign clockdr     = w_sel_bs & ((r_state == S_CAPDR) || (r_state == S_SHDR));
  assign shiftdr     = w_sel_bs & (r_state == S_SHDR);
  assign updatedr    = w_sel_bs & (r_state == S_UPDDR);
  assign clockdr_is  = w_sel_is & ((r_state == S_CAPDR) || (r_state == S_SHDR));
  assign shiftdr_is  = w_sel_is & (r_state == S_SHDR);
  assign updatedr_is = w_sel_is & (r_state == S_UPDDR);

  assign bs_en     = (r_ir_q == I_EXTEST) || (r_ir_q == I_INTSCAN);
  assign TDO       = w_tdo;
  assign TDO_EN    = (r_state == S_SHDR) || (r_state == S_SHIR);
  assign tap_state = r_state;
  assign ir_q      = r_ir_q;

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
IEEE 1149.1-style TAP controller that sequences the s9234 boundary-scan register (BSR) and internal scan register (ISR) chains. It decodes TMS into the 16-state TAP FSM, holds a 3-bit instruction register, and steers clockdr/shiftdr/updatedr to the selected chain. It also drives bs_en and muxes TDO from BSR, ISR, bypass or IR. It sits at chip top, beside s9234_JTAG_BSR, and is clocked by the same CK, which serves as TCK.

Parameters:
IR_W, 3, instruction register width
I_EXTEST, 3'b000, drive pins/core from BSR update latches; BSR selected
I_SAMPLE, 3'b001, capture/shift BSR, normal functional mode; BSR selected
I_INTSCAN, 3'b010, internal scan chain selected
I_BYPASS, 3'b111, 1-bit bypass selected; all undefined codes decode as BYPASS

Ports:
CK  input  1  clock (TCK); all state updates on rising edge
reset  input  1  synchronous, active-high; forces Test-Logic-Reset
TMS  input  1  test mode select
TDI  input  1  serial data in; feeds BSR/ISR externally and IR/bypass internally
TDO_BSR  input  1  serial out of BSR chain
TDO_ISR  input  1  serial out of ISR chain
TDO  output  1  serial data out
TDO_EN  output  1  high only in Shift-DR or Shift-IR
clockdr  output  1  BSR capture/shift enable
shiftdr  output  1  BSR shift select
updatedr  output  1  BSR update strobe
clockdr_is  output  1  ISR capture/shift enable
shiftdr_is  output  1  ISR shift select
updatedr_is  output  1  ISR update strobe
bs_en  output  1  boundary test mode enable
tap_state  output  4  current FSM state
ir_q  output  IR_W  active instruction

Behaviour:
- State encoding (hex): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- Transitions follow IEEE 1149.1 exactly, sampled on TMS at each rising edge of CK.
- From any state, 5 consecutive TMS=1 cycles reach TLR.
- reset=1: next state TLR, ir_q=I_BYPASS, IR shift reg=0, bypass bit=0. This applies mid-shift or mid-update. No update strobe is issued on that edge.
- In TLR, ir_q is reloaded to I_BYPASS every cycle.
- Selection: sel_bs = ir_q in {EXTEST, SAMPLE}; sel_is = ir_q==INTSCAN; otherwise bypass.
- All strobe outputs are combinational from the registered state and ir_q. They are glitch-free relative to CK and change only after a rising edge.
- clockdr = sel_bs & state in {CapDR, ShDR}.
- shiftdr = sel_bs & state==ShDR.
- updatedr = sel_bs & state==UpdDR, so it is high for exactly one cycle per DR scan.
- The _is outputs follow the same equations with sel_is.
- Pause, Exit and Select states leave all strobes at 0, so chains hold their contents.
- bs_en = ir_q in {EXTEST, INTSCAN}. It changes only on the UpdIR exit edge or on reset/TLR. It is 0 after reset.
- IR path:
  - CapIR loads shift reg with {0..0,01}.
  - ShIR shifts right, TDI entering the MSB; TDO = shift reg[0].
  - UpdIR: ir_q <= shift reg on the edge leaving UpdIR.
  - ir_q is stable during DR scans.
- Bypass path: CapDR loads 0; ShDR loads TDI; TDO = bypass bit.
- TDO mux:
  - ShIR: IR LSB.
  - ShDR: TDO_BSR, TDO_ISR or bypass, per selection.
  - Otherwise: 0.
  - TDO_EN follows the same state condition.
- Reset values: tap_state=F, ir_q=3'b111, TDO=0, TDO_EN=0, all strobes 0, bs_en=0.
- Latency: strobes are asserted in the cycle the FSM enters the state. The BSR/ISR act on the next CK edge.

Test Plan:
- Reset: assert reset 1 cycle with TMS=0 -> tap_state=F, ir_q=111, bs_en=0, all strobes 0. Next edge with TMS=0 -> tap_state=C.
- IR load EXTEST: from RTI, TMS seq 1,1,0,0 then shift 000 (TMS=0,0,1), then 1,0 -> TDO during shift reads 1,0,0 (capture pattern 001). ir_q=000 after UpdIR edge; bs_en=1 from that edge.
- DR scan BSR under SAMPLE: load 001, then SelDR→CapDR→ShDR x72→Ex1DR→UpdDR.
  - clockdr high 73 cycles, shiftdr high 72 cycles, updatedr high exactly 1 cycle.
  - clockdr_is/shiftdr_is/updatedr_is stay 0 throughout; TDO mirrors TDO_BSR while in ShDR.
- INTSCAN steering: ir_q=010 -> only the _is strobes pulse; bs_en=1. Driving TDO_ISR=1, TDO_BSR=0 in ShDR -> TDO=1.
- Bypass and undefined code: load 101 -> ir_q reads 101 but decodes as bypass. Shift TDI pattern 1,0,1,1 in ShDR -> TDO shows 0,1,0,1 (1-cycle delay, leading captured 0). No chain strobes.
- Abort paths:
  - Reset asserted in ShDR -> next state F, updatedr never pulses, bs_en=0.
  - Separately, 5x TMS=1 from PauseIR -> state F, ir_q=111.
